// File: rtl/nested_irq_pc_unit_pkg.sv
// Shared constants and helpers for the nested-interrupt next-PC unit.
package nested_irq_pc_unit_pkg;

  localparam int unsigned MaxIrq       = 32;
  localparam logic [31:0] DefVecBase   = 32'h0000_0038;
  localparam logic [31:0] DefVecStride = 32'h0000_0038;
  localparam int unsigned LVL_USER     = 0;

  // Callers truncate the result to their own address width.
  function automatic logic [63:0] vec_addr(input int unsigned k,
                                           input logic [63:0] base,
                                           input logic [63:0] stride);
    return base + 64'(k) * stride;
  endfunction

  // Index of the highest set bit; 0 when the vector is empty.
  function automatic int unsigned msb_index(input logic [MaxIrq-1:0] vec);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MaxIrq; i++) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/pc_save_stack.sv
// Return-address LIFO; dout shows the top entry whenever the stack is non-empty.
module pc_save_stack #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PtrW = $clog2(DEPTH + 1);
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  sp_q;
  logic [PtrW-1:0]  top;

  assign empty = (sp_q == '0);
  assign full  = (sp_q == PtrW'(DEPTH));
  assign top   = sp_q - PtrW'(1);
  assign dout  = empty ? '0 : mem_q[top[IdxW-1:0]];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sp_q <= '0;
    end else if (push && !full) begin
      sp_q <= sp_q + PtrW'(1);
    end else if (pop && !empty) begin
      sp_q <= sp_q - PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem_q[sp_q[IdxW-1:0]] <= din;
  end

`ifndef SYNTHESIS
  assert property (@(posedge clk) disable iff (clr) !(push && pop));
`endif

endmodule

// File: rtl/nested_irq_pc_unit.sv
// Next-PC generator with priority-nested interrupts and a hardware return-address stack.
module nested_irq_pc_unit
  import nested_irq_pc_unit_pkg::*;
#(
  parameter int unsigned       NUM_IRQ    = 3,
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] VEC_BASE   = ADDR_W'(DefVecBase),
  parameter logic [ADDR_W-1:0] VEC_STRIDE = ADDR_W'(DefVecStride),
  localparam int unsigned      LvlW       = $clog2(NUM_IRQ + 1)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              enable,
  input  logic              int_en,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic              irq_done,
  input  logic [ADDR_W-1:0] PC_old,
  input  logic [ADDR_W-1:0] ext_18,
  input  logic [25:0]       jmp_dest,
  input  logic              branch,
  input  logic              jmp,
  input  logic              Jr,
  input  logic [ADDR_W-1:0] RS,
  output logic [ADDR_W-1:0] PC_next,
  output logic [ADDR_W-1:0] sequencial_addr,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic [NUM_IRQ-1:0] irq_running,
  output logic [LvlW-1:0]   cur_level,
  output logic              stack_err
);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [NUM_IRQ-1:0] ack_q, ack_d;
  logic [NUM_IRQ-1:0] run_q, run_d;
  logic [LvlW-1:0]    lvl_q, lvl_d;
  logic               err_q, err_d;

  logic [ADDR_W-1:0]  branch_addr, jmp_addr, normal_next, vec;
  logic [NUM_IRQ-1:0] pending, win_onehot, clr_mask, remaining;
  int unsigned        win;
  logic               preempt;
  logic [LvlW-1:0]    lvl_pop;

  logic               stk_push, stk_pop, stk_empty, stk_full;
  logic [ADDR_W-1:0]  stk_dout;

  assign sequencial_addr = PC_old + ADDR_W'(4);
  assign branch_addr     = sequencial_addr + ext_18;
  assign jmp_addr        = ADDR_W'({PC_old[ADDR_W-1 -: 4], jmp_dest, 2'b00});
  assign normal_next     = jmp ? (Jr ? RS : jmp_addr) : (branch ? branch_addr : sequencial_addr);

  assign pending    = int_en ? (irq & ~irq_mask & ~run_q) : '0;
  assign win        = msb_index(MaxIrq'(pending));
  assign win_onehot = NUM_IRQ'(1) << win;
  assign preempt    = (|pending) && ((win + 32'd1) > 32'(lvl_q));
  assign vec        = ADDR_W'(vec_addr(win, 64'(VEC_BASE), 64'(VEC_STRIDE)));

  // Level being retired on a return and the level left underneath it.
  always_comb begin
    clr_mask = '0;
    for (int k = 0; k < int'(NUM_IRQ); k++) begin
      clr_mask[k] = (lvl_q == LvlW'(k + 1));
    end
  end

  assign remaining = run_q & ~clr_mask;
  assign lvl_pop   = (|remaining) ? LvlW'(msb_index(MaxIrq'(remaining)) + 1) : LvlW'(LVL_USER);

  always_comb begin
    pc_d     = pc_q;
    run_d    = run_q;
    lvl_d    = lvl_q;
    err_d    = err_q;
    ack_d    = '0;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    if (enable) begin
      if (irq_done && !stk_empty) begin
        stk_pop = 1'b1;
        pc_d    = stk_dout;
        run_d   = remaining;
        lvl_d   = lvl_pop;
      end else if (irq_done) begin
        err_d = 1'b1;
        pc_d  = normal_next;
      end else if (preempt) begin
        stk_push = 1'b1;
        pc_d     = vec;
        run_d    = run_q | win_onehot;
        ack_d    = win_onehot;
        lvl_d    = LvlW'(win + 32'd1);
      end else begin
        pc_d = normal_next;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pc_q  <= '0;
      ack_q <= '0;
      run_q <= '0;
      lvl_q <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ack_q <= ack_d;
      run_q <= run_d;
      lvl_q <= lvl_d;
      err_q <= err_d;
    end
  end

  pc_save_stack #(
    .DEPTH(NUM_IRQ),
    .WIDTH(ADDR_W)
  ) u_stack (
    .clk  (clk),
    .clr  (clr),
    .push (stk_push),
    .pop  (stk_pop),
    .din  (normal_next),
    .dout (stk_dout),
    .empty(stk_empty),
    .full (stk_full)
  );

`ifndef SYNTHESIS
  // Strict priority nesting keeps the stack within NUM_IRQ entries.
  assert property (@(posedge clk) disable iff (clr) !(stk_push && stk_full));
`endif

  assign PC_next     = pc_q;
  assign irq_ack     = ack_q;
  assign irq_running = run_q;
  assign cur_level   = lvl_q;
  assign stack_err   = err_q;

endmodule

// File: tb/tb_nested_irq_pc_unit.sv
// Scoreboard bench: directed steps queue expected outputs, a monitor checks each clock.
module tb_nested_irq_pc_unit;

  logic        clk = 1'b0;
  logic        clr, enable, int_en, irq_done, branch, jmp, Jr;
  logic [2:0]  irq, irq_mask;
  logic [31:0] PC_old, ext_18, RS;
  logic [25:0] jmp_dest;
  logic [31:0] PC_next, sequencial_addr;
  logic [2:0]  irq_ack, irq_running;
  logic [1:0]  cur_level;
  logic        stack_err;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [2:0]  ack;
    logic [2:0]  run;
    logic [1:0]  lvl;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  nested_irq_pc_unit dut (
    .clk            (clk),
    .clr            (clr),
    .enable         (enable),
    .int_en         (int_en),
    .irq            (irq),
    .irq_mask       (irq_mask),
    .irq_done       (irq_done),
    .PC_old         (PC_old),
    .ext_18         (ext_18),
    .jmp_dest       (jmp_dest),
    .branch         (branch),
    .jmp            (jmp),
    .Jr             (Jr),
    .RS             (RS),
    .PC_next        (PC_next),
    .sequencial_addr(sequencial_addr),
    .irq_ack        (irq_ack),
    .irq_running    (irq_running),
    .cur_level      (cur_level),
    .stack_err      (stack_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // One registered result per enabled clock edge.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({e.name, ".pc"},  PC_next,     e.pc);
      chk({e.name, ".ack"}, irq_ack,     32'(e.ack));
      chk({e.name, ".run"}, irq_running, 32'(e.run));
      chk({e.name, ".lvl"}, cur_level,   32'(e.lvl));
      chk({e.name, ".err"}, stack_err,   32'(e.err));
    end
  end

  task automatic cyc(input string name, input logic [31:0] pc, input logic [2:0] ack,
                     input logic [2:0] run, input logic [1:0] lvl, input logic err);
    exp_t e;
    e.name = name;
    e.pc   = pc;
    e.ack  = ack;
    e.run  = run;
    e.lvl  = lvl;
    e.err  = err;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stimulus
    clr = 1'b1; enable = 1'b1; int_en = 1'b0; irq_done = 1'b0;
    branch = 1'b0; jmp = 1'b0; Jr = 1'b0;
    irq = 3'b000; irq_mask = 3'b000;
    PC_old = '0; ext_18 = '0; RS = '0; jmp_dest = '0;
    @(negedge clk);
    chk("rst.pc",  PC_next,     32'h0);
    chk("rst.ack", irq_ack,     32'h0);
    chk("rst.run", irq_running, 32'h0);
    chk("rst.lvl", cur_level,   32'h0);
    chk("rst.err", stack_err,   32'h0);
    clr = 1'b0;

    PC_old = 32'h100; #1;
    chk("seq_addr", sequencial_addr, 32'h104);
    cyc("seq", 32'h104, 3'b000, 3'b000, 2'd0, 1'b0);
    branch = 1'b1; ext_18 = 32'h10;
    cyc("branch_fwd", 32'h114, 3'b000, 3'b000, 2'd0, 1'b0);
    ext_18 = 32'hFFFF_FFF0;
    cyc("branch_back", 32'hF4, 3'b000, 3'b000, 2'd0, 1'b0);
    branch = 1'b0; jmp = 1'b1; Jr = 1'b1; RS = 32'h400;
    cyc("jr", 32'h400, 3'b000, 3'b000, 2'd0, 1'b0);
    Jr = 1'b0; PC_old = 32'hF000_0000; jmp_dest = 26'h123;
    cyc("jmp", 32'hF000_048C, 3'b000, 3'b000, 2'd0, 1'b0);

    jmp = 1'b0; int_en = 1'b1; irq = 3'b001; PC_old = 32'h200;
    cyc("enter_l0", 32'h38, 3'b001, 3'b001, 2'd1, 1'b0);
    irq = 3'b000; PC_old = 32'h38;
    cyc("in_l0", 32'h3C, 3'b000, 3'b001, 2'd1, 1'b0);
    irq = 3'b100; PC_old = 32'h40;
    cyc("enter_l2", 32'hA8, 3'b100, 3'b101, 2'd3, 1'b0);
    irq = 3'b010; PC_old = 32'hA8;
    cyc("no_preempt", 32'hAC, 3'b000, 3'b101, 2'd3, 1'b0);
    irq_done = 1'b1; PC_old = 32'hAC;
    cyc("ret_l2", 32'h44, 3'b000, 3'b001, 2'd1, 1'b0);
    irq_done = 1'b0; PC_old = 32'h44;
    cyc("enter_l1", 32'h70, 3'b010, 3'b011, 2'd2, 1'b0);
    irq = 3'b000; PC_old = 32'h70;
    cyc("in_l1", 32'h74, 3'b000, 3'b011, 2'd2, 1'b0);
    irq_done = 1'b1; PC_old = 32'h74;
    cyc("ret_l1", 32'h48, 3'b000, 3'b001, 2'd1, 1'b0);
    PC_old = 32'h48;
    cyc("ret_l0", 32'h204, 3'b000, 3'b000, 2'd0, 1'b0);

    irq_done = 1'b0; irq_mask = 3'b111; irq = 3'b111; PC_old = 32'h300;
    cyc("masked", 32'h304, 3'b000, 3'b000, 2'd0, 1'b0);
    irq_mask = 3'b000; int_en = 1'b0; PC_old = 32'h304;
    cyc("int_off", 32'h308, 3'b000, 3'b000, 2'd0, 1'b0);
    irq = 3'b000; int_en = 1'b1; irq_done = 1'b1; PC_old = 32'h308;
    cyc("underflow", 32'h30C, 3'b000, 3'b000, 2'd0, 1'b1);
    irq_done = 1'b0; PC_old = 32'h30C;
    cyc("err_sticky", 32'h310, 3'b000, 3'b000, 2'd0, 1'b1);

    enable = 1'b0; irq = 3'b001; PC_old = 32'h600;
    cyc("stall", 32'h310, 3'b000, 3'b000, 2'd0, 1'b1);
    enable = 1'b1;
    cyc("enter_after_stall", 32'h38, 3'b001, 3'b001, 2'd1, 1'b1);
    irq = 3'b100; PC_old = 32'h40;
    cyc("nest_l2", 32'hA8, 3'b100, 3'b101, 2'd3, 1'b1);
    irq = 3'b000; PC_old = 32'hA8;
    cyc("deep", 32'hAC, 3'b000, 3'b101, 2'd3, 1'b1);

    #2 clr = 1'b1;
    #1;
    chk("async_clr.pc",  PC_next,     32'h0);
    chk("async_clr.ack", irq_ack,     32'h0);
    chk("async_clr.run", irq_running, 32'h0);
    chk("async_clr.lvl", cur_level,   32'h0);
    chk("async_clr.err", stack_err,   32'h0);
    @(negedge clk);
    clr = 1'b0; irq_done = 1'b1; PC_old = 32'h100;
    cyc("post_clr_empty", 32'h104, 3'b000, 3'b000, 2'd0, 1'b1);
    irq_done = 1'b0;
    cyc("final", 32'h104, 3'b000, 3'b000, 2'd0, 1'b1);

    @(negedge clk);
    chk("drain", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nested_irq_pc_unit.md
Name: nested_irq_pc_unit

Overview:
- Next-PC generator with a parametrised, priority-nested interrupt controller.
- Generalises the fixed three-level PC/backup scheme to NUM_IRQ levels, with a per-level mask, a global enable and a hardware LIFO of return addresses.
- Sits between the decoder (branch/jmp/Jr/eret-done) and the PC register.
- Drives PC_next every cycle: sequential, branch, jump, vector or return address.

Parameters:
- NUM_IRQ, 3: number of interrupt levels. Index NUM_IRQ-1 has the highest priority.
- ADDR_W, 32: PC width.
- VEC_BASE, 32'h00000038: vector address of level 0.
- VEC_STRIDE, 32'h00000038: spacing between level vectors. Vector(k) = VEC_BASE + k*VEC_STRIDE, truncated to ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset, asynchronous, active-high.
- enable  in  1  advance; 0 = stall, all state held.
- int_en  in  1  global interrupt enable.
- irq  in  NUM_IRQ  level-sensitive requests; each must be held until its irq_ack.
- irq_mask  in  NUM_IRQ  1 = level masked.
- irq_done  in  1  one-cycle pulse from the decoder on return-from-interrupt.
- PC_old  in  ADDR_W  current PC.
- ext_18  in  ADDR_W  sign-extended branch offset.
- jmp_dest  in  26  jump target field.
- branch, jmp, Jr  in  1 each  control-flow selects.
- RS  in  ADDR_W  register target for Jr.
- PC_next  out  ADDR_W  registered next PC.
- sequencial_addr  out  ADDR_W  PC_old+4, combinational.
- irq_ack  out  NUM_IRQ  one-hot, one-cycle pulse when a level is entered.
- irq_running  out  NUM_IRQ  per-level in-service flags.
- cur_level  out  $clog2(NUM_IRQ+1)  0 = user, k+1 = level k active.
- stack_err  out  1  sticky; set on irq_done with an empty stack.

Behaviour:
- Reset (async, clr=1):
  - PC_next=0, irq_running=0, irq_ack=0, cur_level=0, stack_err=0.
  - Stack pointer=0. Stack contents are don't-care.
- Combinational addresses:
  - sequencial_addr = PC_old+4.
  - branch_addr = sequencial_addr + ext_18.
  - jmp_addr = {PC_old[ADDR_W-1:ADDR_W-4], jmp_dest, 2'b00}.
  - normal_next = jmp ? (Jr ? RS : jmp_addr) : (branch ? branch_addr : sequencial_addr).
  - All arithmetic is modulo 2^ADDR_W.
- pending = irq & ~irq_mask & ~irq_running, gated by int_en. The winner is the highest set index h.
- Preemption: taken only when h+1 > cur_level. Equal or lower levels wait; no re-entry of a running level.
- Per rising clk with enable=1, priority order:
  1. irq_done and stack non-empty:
     - Pop; PC_next = popped address.
     - Clear the irq_running bit of cur_level.
     - cur_level = highest remaining running level +1, or 0 if none.
     - Any pending interrupt is evaluated next cycle; done always wins a simultaneous request.
  2. irq_done and stack empty: stack_err=1, PC_next=normal_next, nothing else changes.
  3. Preemption: push normal_next, so the interrupted instruction's control flow completes on return. Then:
     - PC_next = Vector(h).
     - irq_running[h]=1, cur_level=h+1.
     - irq_ack[h]=1 for exactly this cycle.
  4. Otherwise PC_next = normal_next.
- enable=0: PC_next, stack, flags and cur_level hold. irq_ack=0. irq_done is ignored, so the decoder must not pulse it during a stall.
- Stack depth is NUM_IRQ. Strict nesting by priority bounds the depth, so overflow is unreachable. An assertion flags a push when the stack is full.
- Nested return always pops to the level below, restoring cur_level correctly for arbitrary nesting order.
- irq_ack is registered and cleared on the following cycle.

Decomposition:
- Shared package:
  - VEC_BASE/VEC_STRIDE defaults.
  - Function vec_addr(k).
  - Level-encoding constant LVL_USER=0.
  - Priority-encoder function msb_index(vector).
- Sub-module pc_save_stack:
  - Parametrised LIFO with DEPTH and WIDTH parameters.
  - Ports: clk, clr, push, pop, din, dout, empty, full.
  - Same-cycle push+pop is illegal and asserted.

Test Plan:
- Reset then PC_old=0x100, no controls -> PC_next=0x104; then branch=1, ext_18=0x10 -> PC_next=0x114; jmp=1, Jr=1, RS=0x400 -> PC_next=0x400.
- irq[0]=1, int_en=1, PC_old=0x200 -> PC_next=0x38, irq_ack=001 for one cycle, cur_level=1. Later irq_done -> PC_next=0x204, cur_level=0, irq_running=000.
- Inside level 0 (PC_old=0x40), raise irq[2] -> PC_next=0xA8, cur_level=3. irq_done -> 0x44, cur_level=1. irq_done -> 0x204, cur_level=0.
- Inside level 2, raise irq[1] -> no preemption. After irq_done returns to level 0 context (cur_level=1), next cycle PC_next=0x70.
- irq_mask=111, or int_en=0, with irq=111 -> sequential PC only. irq_done at cur_level=0 -> stack_err=1 and sticky until clr.
- Assert clr mid-nesting (cur_level=3) -> PC_next=0, irq_running=0, cur_level=0 immediately, without waiting for a clock edge. enable=0 with irq pending -> PC_next held, no irq_ack.
